apb2lb_bridge: RTL and testbench
================================

// Module: apb2lb_bridge
// PURPOSE
//  APB4 slave to register-map Local Bus (LB) master bridge, directly upstream of the CSR map.
//  Converts each APB transfer into exactly one LB write (wen/wready handshake) or LB read (ren/rvalid).
//  Adds a wait-cycle timeout that completes the APB transfer with PSLVERR when the map does not respond.
// PARAMETERS
//  ADDR_W   16  address width, APB and LB
//  DATA_W   32  data width (multiple of 8); STRB_W = DATA_W/8
//  TIMEOUT  16  max LB wait cycles before error response; 0 = no timeout
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       reset, asynchronous, active-high
//  psel       in   1       APB select
//  penable    in   1       APB access phase
//  pwrite     in   1       APB direction, 1 = write
//  paddr      in   ADDR_W  APB address
//  pwdata     in   DATA_W  APB write data
//  pstrb      in   STRB_W  APB write strobes
//  prdata     out  DATA_W  APB read data, valid when pready=1
//  pready     out  1       APB transfer complete
//  pslverr    out  1       APB error, valid when pready=1
//  lb_waddr   out  ADDR_W  LB write address
//  lb_wdata   out  DATA_W  LB write data
//  lb_wstrb   out  STRB_W  LB write strobes
//  lb_wen     out  1       LB write request, held until accepted
//  lb_wready  in   1       LB write accepted when high with lb_wen
//  lb_raddr   out  ADDR_W  LB read address
//  lb_ren     out  1       LB read request, 1-cycle pulse
//  lb_rdata   in   DATA_W  LB read data, valid with lb_rvalid
//  lb_rvalid  in   1       LB read data valid
// BEHAVIOUR
//  - All outputs registered. Reset value of every output is 0; FSM -> IDLE, timeout counter -> 0.
//  - FSM states: IDLE, WRITE, READ, RWAIT, RESP.
//  - IDLE: on psel=1 & penable=0 (setup):
//    - latch paddr into lb_waddr/lb_raddr; latch pwdata, pstrb.
//    - pwrite=1: -> WRITE, lb_wen<=1.
//    - pwrite=0: -> READ, lb_ren<=1.
//    - pstrb ignored on reads; write with pstrb=0 still issued.
//  - WRITE: lb_wen held 1; addr/data/strb stable.
//    - lb_wready=1: lb_wen<=0, pready<=1, pslverr<=0, -> RESP.
//  - READ: lb_ren<=0, -> RWAIT. lb_rvalid in this cycle is captured exactly as in RWAIT.
//  - RWAIT:
//    - lb_rvalid=1: prdata<=lb_rdata, pready<=1, pslverr<=0, -> RESP.
//  - Timeout, TIMEOUT>0: counter clears on leaving IDLE and increments each WRITE/READ/RWAIT cycle without handshake.
//    - Counter reaching TIMEOUT: drop lb_wen, pready<=1, pslverr<=1, prdata<=0, -> RESP.
//    - Handshake in the same cycle as expiry wins: normal response.
//  - RESP: pready=1 exactly one cycle (penable=1 here per APB); pready<=0, pslverr<=0, -> IDLE.
//    - prdata holds until the next read completes.
//  - Stray lb_rvalid or lb_wready outside WRITE/READ/RWAIT is ignored, e.g. a late response after timeout.
//  - Back-to-back: setup detected in the cycle after RESP (IDLE) with no extra bubble.
//  - Latency from setup cycle T0, zero-wait map:
//    - write: lb_wen at T1, pready at T2.
//    - read: lb_ren at T1, rvalid at T2, pready at T3.
//  - psel dropped mid-transfer (protocol violation): transfer still completes on LB; pready still pulses.
//  - Async rst mid-transfer: all outputs 0 immediately; no LB request re-issued after release.
// TESTING
//  1. Write 0x40 <- 0xDEADBEEF, strb 0xF, lb_wready=1 -> lb_wen high 1 cycle with those values; pready at T2; pslverr=0.
//  2. Read 0x44, map returns 0x00020010 one cycle after lb_ren -> single lb_ren pulse; prdata=0x00020010; pready at T3.
//  3. Write with lb_wready low 5 cycles -> lb_wen and data stable 6 cycles; pready 1 cycle after accept.
//  4. Read, lb_rvalid never, TIMEOUT=16 -> pready with pslverr=1, prdata=0; next read of 0x40 completes normally.
//  5. rst asserted 2 cycles into a stalled write -> lb_wen, pready drop asynchronously; after release no spurious LB request.
//  6. Back-to-back write 0x40 then read 0x40, zero-wait map -> second setup accepted the cycle after pready; read returns written data.

Source files
------------

// File: rtl/apb2lb_bridge.sv
// ---------------------------------------------------------------------------
// apb2lb_bridge
//
// APB4 slave to register-map Local Bus (LB) master bridge. Every APB transfer
// becomes exactly one LB write (lb_wen held until lb_wready) or one LB read
// (single-cycle lb_ren pulse, data returned with lb_rvalid). A wait-cycle
// timeout completes the APB transfer with pslverr when the map stays silent.
//
// Parameters
//   ADDR_W   address width, APB and LB
//   DATA_W   data width (multiple of 8); strobe width is DATA_W/8
//   TIMEOUT  max LB wait cycles before an error response; 0 disables it
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   psel       in   APB select
//   penable    in   APB access phase
//   pwrite     in   APB direction, 1 = write
//   paddr      in   APB address
//   pwdata     in   APB write data
//   pstrb      in   APB write strobes
//   prdata     out  APB read data, valid with pready
//   pready     out  APB transfer complete (one-cycle pulse)
//   pslverr    out  APB error, valid with pready
//   lb_waddr   out  LB write address
//   lb_wdata   out  LB write data
//   lb_wstrb   out  LB write strobes
//   lb_wen     out  LB write request, held until accepted
//   lb_wready  in   LB write accept, qualified by lb_wen
//   lb_raddr   out  LB read address
//   lb_ren     out  LB read request, one-cycle pulse
//   lb_rdata   in   LB read data, valid with lb_rvalid
//   lb_rvalid  in   LB read data valid
//
// All outputs are registered and reset to 0.
// ---------------------------------------------------------------------------
module apb2lb_bridge #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   // APB slave side
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_W-1:0]     paddr,
   input  logic [DATA_W-1:0]     pwdata,
   input  logic [DATA_W/8-1:0]   pstrb,
   output logic [DATA_W-1:0]     prdata,
   output logic                  pready,
   output logic                  pslverr,
   // LB master side
   output logic [ADDR_W-1:0]     lb_waddr,
   output logic [DATA_W-1:0]     lb_wdata,
   output logic [DATA_W/8-1:0]   lb_wstrb,
   output logic                  lb_wen,
   input  logic                  lb_wready,
   output logic [ADDR_W-1:0]     lb_raddr,
   output logic                  lb_ren,
   input  logic [DATA_W-1:0]     lb_rdata,
   input  logic                  lb_rvalid
);

   localparam int STRB_W = DATA_W / 8;

   // The counter only has to hold 0..TIMEOUT-1: the wait cycle that would
   // bring it to TIMEOUT is the expiry cycle itself.
   localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam bit              TO_EN    = (TIMEOUT > 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_RWAIT,
      S_RESP
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   prdata_q, prdata_d;
   logic                pready_q, pready_d;
   logic                pslverr_q, pslverr_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic                wen_q, wen_d;
   logic [ADDR_W-1:0]   raddr_q, raddr_d;
   logic                ren_q, ren_d;

   logic                expired;

   // Expiry fires on the TIMEOUT-th wait cycle without a handshake; the
   // handshake branches are tested first so a response in that cycle wins.
   assign expired = TO_EN && (cnt_q == CNT_LAST);

   // ------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      prdata_d  = prdata_q;
      pready_d  = pready_q;
      pslverr_d = pslverr_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      wen_d     = wen_q;
      raddr_d   = raddr_q;
      ren_d     = ren_q;

      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (psel && !penable) begin
               waddr_d = paddr;
               raddr_d = paddr;
               wdata_d = pwdata;
               wstrb_d = pstrb;
               if (pwrite) begin
                  wen_d   = 1'b1;
                  state_d = S_WRITE;
               end else begin
                  ren_d   = 1'b1;
                  state_d = S_READ;
               end
            end
         end

         S_WRITE: begin
            if (lb_wready) begin
               wen_d     = 1'b0;
               pready_d  = 1'b1;
               pslverr_d = 1'b0;
               state_d   = S_RESP;
            end else if (expired) begin
               wen_d     = 1'b0;
               pready_d  = 1'b1;
               pslverr_d = 1'b1;
               prdata_d  = '0;
               state_d   = S_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // READ only retires the ren pulse; a response already present in
         // this cycle is handled exactly as in RWAIT.
         S_READ, S_RWAIT: begin
            ren_d   = 1'b0;
            state_d = S_RWAIT;
            if (lb_rvalid) begin
               prdata_d  = lb_rdata;
               pready_d  = 1'b1;
               pslverr_d = 1'b0;
               state_d   = S_RESP;
            end else if (expired) begin
               pready_d  = 1'b1;
               pslverr_d = 1'b1;
               prdata_d  = '0;
               state_d   = S_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_RESP: begin
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            state_d   = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         wen_q     <= 1'b0;
         raddr_q   <= '0;
         ren_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         wen_q     <= wen_d;
         raddr_q   <= raddr_d;
         ren_q     <= ren_d;
      end
   end

   assign prdata   = prdata_q;
   assign pready   = pready_q;
   assign pslverr  = pslverr_q;
   assign lb_waddr = waddr_q;
   assign lb_wdata = wdata_q;
   assign lb_wstrb = wstrb_q;
   assign lb_wen   = wen_q;
   assign lb_raddr = raddr_q;
   assign lb_ren   = ren_q;

endmodule

// File: tb/tb_apb2lb_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb2lb_bridge
//
// Drives APB transfers into apb2lb_bridge while acting as the LB register map.
// A transfer is described by the cycle k (counted from the setup cycle T0)
// in which the map responds; the response is then expected at T(k+1), or at
// T(TIMEOUT+1) with pslverr when k exceeds TIMEOUT. The map keeps its
// contents in an associative array so reads return earlier writes.
// ---------------------------------------------------------------------------
module tb_apb2lb_bridge;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        psel, penable, pwrite;
   logic [15:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic [15:0] lb_waddr, lb_raddr;
   logic [31:0] lb_wdata, lb_rdata;
   logic [3:0]  lb_wstrb;
   logic        lb_wen, lb_wready, lb_ren, lb_rvalid;

   apb2lb_bridge #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .pstrb     (pstrb),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr),
      .lb_waddr  (lb_waddr),
      .lb_wdata  (lb_wdata),
      .lb_wstrb  (lb_wstrb),
      .lb_wen    (lb_wen),
      .lb_wready (lb_wready),
      .lb_raddr  (lb_raddr),
      .lb_ren    (lb_ren),
      .lb_rdata  (lb_rdata),
      .lb_rvalid (lb_rvalid)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   string       cur_tag = "reset";
   int          cur_j = 0;
   logic [31:0] last_prd = '0;
   logic [31:0] mem [logic [15:0]];

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          k;       // map response cycle relative to setup
      bit          drop;    // master drops psel after setup
      int          exp_e;   // cycle carrying pready
      bit          exp_err;
      logic [31:0] exp_prd;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (%s cyc %0d): actual %h required %h", name, cur_tag, cur_j, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'd0, act}, {31'd0, exp});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] map_read(input logic [15:0] a);
      if (mem.exists(a)) return mem[a];
      return {16'hA5A5, a};
   endfunction

   // Response timing derived from the map response cycle k.
   task automatic expect_resp(input int k, output int e, output bit err);
      if (k <= TO) begin
         e   = k + 1;
         err = 1'b0;
      end else begin
         e   = TO + 1;
         err = 1'b1;
      end
   endtask

   task automatic idle(input int n, input bit stray);
      for (int i = 0; i < n; i++) begin
         tick();
         cur_j = -1;
         chk1("idle_pready", pready, 1'b0);
         chk1("idle_wen", lb_wen, 1'b0);
         chk1("idle_ren", lb_ren, 1'b0);
         chk("idle_prdata", prdata, last_prd);
         psel      = 1'b0;
         penable   = 1'b0;
         lb_wready = stray;
         lb_rvalid = stray;
         lb_rdata  = $urandom;
      end
   endtask

   task automatic apb_xfer(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int k, input bit drop,
                           input int exp_e, input bit exp_err, input logic [31:0] exp_prd);
      logic [31:0] rd;
      logic [31:0] nv;
      rd = map_read(addr);
      tick();
      cur_j = 0;
      chk1("t0_pready", pready, 1'b0);
      chk1("t0_wen", lb_wen, 1'b0);
      chk1("t0_ren", lb_ren, 1'b0);
      psel      = 1'b1;
      penable   = 1'b0;
      pwrite    = wr;
      paddr     = addr;
      pwdata    = data;
      pstrb     = strb;
      lb_wready = 1'b0;
      lb_rvalid = 1'b0;
      lb_rdata  = $urandom;
      for (int j = 1; j <= exp_e; j++) begin
         tick();
         cur_j = j;
         chk1("pready", pready, j == exp_e);
         chk1("lb_wen", lb_wen, wr && (j < exp_e));
         chk1("lb_ren", lb_ren, !wr && (j == 1));
         if (wr && (j < exp_e)) begin
            chk("lb_waddr", {16'd0, lb_waddr}, {16'd0, addr});
            chk("lb_wdata", lb_wdata, data);
            chk("lb_wstrb", {28'd0, lb_wstrb}, {28'd0, strb});
         end
         if (!wr && (j == 1)) chk("lb_raddr", {16'd0, lb_raddr}, {16'd0, addr});
         if (j == exp_e) begin
            chk1("pslverr", pslverr, exp_err);
            chk("prdata", prdata, exp_prd);
         end
         if (drop) begin
            psel    = 1'b0;
            penable = 1'b0;
         end else begin
            penable = 1'b1;
         end
         lb_wready = wr && (j == k);
         lb_rvalid = !wr && (j == k);
         lb_rdata  = (j == k) ? rd : $urandom;
         if (wr && (j == k) && (k <= TO)) begin
            nv = map_read(addr);
            for (int b = 0; b < 4; b++) if (strb[b]) nv[8*b +: 8] = data[8*b +: 8];
            mem[addr] = nv;
         end
      end
      last_prd = exp_prd;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1);
   end

   initial begin
      int          e;
      bit          err;
      bit          wr;
      logic [15:0] a;
      logic [31:0] d, ep;
      int          k;
      int          r;

      rst = 1'b1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      lb_wready = 1'b0; lb_rvalid = 1'b0; lb_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk1("rst_pready", pready, 1'b0);
      chk1("rst_pslverr", pslverr, 1'b0);
      chk("rst_prdata", prdata, 32'd0);
      chk1("rst_wen", lb_wen, 1'b0);
      chk1("rst_ren", lb_ren, 1'b0);
      chk("rst_waddr", {16'd0, lb_waddr}, 32'd0);
      chk("rst_raddr", {16'd0, lb_raddr}, 32'd0);
      chk("rst_wdata", lb_wdata, 32'd0);
      chk("rst_wstrb", {28'd0, lb_wstrb}, 32'd0);
      rst = 1'b0;

      mem[16'h0044] = 32'h00020010;

      //          wr    addr      data          strb  k    drop  e   err   prdata
      vecs[0]  = '{1'b1, 16'h0040, 32'hDEADBEEF, 4'hF, 1,   1'b0, 2,  1'b0, 32'h00000000};
      vecs[1]  = '{1'b0, 16'h0044, 32'h0,        4'h0, 2,   1'b0, 3,  1'b0, 32'h00020010};
      vecs[2]  = '{1'b1, 16'h0050, 32'h12345678, 4'hF, 6,   1'b0, 7,  1'b0, 32'h00020010};
      vecs[3]  = '{1'b0, 16'h0060, 32'h0,        4'h0, 100, 1'b0, 17, 1'b1, 32'h00000000};
      vecs[4]  = '{1'b0, 16'h0040, 32'h0,        4'h0, 2,   1'b0, 3,  1'b0, 32'hDEADBEEF};
      vecs[5]  = '{1'b1, 16'h0040, 32'hCAFE0000, 4'hC, 1,   1'b0, 2,  1'b0, 32'hDEADBEEF};
      vecs[6]  = '{1'b0, 16'h0040, 32'h0,        4'h0, 2,   1'b0, 3,  1'b0, 32'hCAFEBEEF};
      vecs[7]  = '{1'b1, 16'h0050, 32'hFFFFFFFF, 4'h0, 3,   1'b0, 4,  1'b0, 32'hCAFEBEEF};
      vecs[8]  = '{1'b0, 16'h0050, 32'h0,        4'h0, 16,  1'b0, 17, 1'b0, 32'h12345678};
      vecs[9]  = '{1'b1, 16'h0070, 32'h0000AAAA, 4'hF, 17,  1'b0, 17, 1'b1, 32'h00000000};
      vecs[10] = '{1'b0, 16'h0070, 32'h0,        4'h0, 1,   1'b0, 2,  1'b0, 32'hA5A50070};
      vecs[11] = '{1'b1, 16'h0044, 32'h00000001, 4'h1, 2,   1'b1, 3,  1'b0, 32'hA5A50070};
      vecs[12] = '{1'b0, 16'h0044, 32'h0,        4'h0, 1,   1'b0, 2,  1'b0, 32'h00020001};

      // Back-to-back: no idle cycle between table entries.
      for (int i = 0; i < 13; i++) begin
         cur_tag = $sformatf("vec%0d", i);
         apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].k,
                  vecs[i].drop, vecs[i].exp_e, vecs[i].exp_err, vecs[i].exp_prd);
      end
      idle(1, 1'b0);

      // Read timeout, then a late map response that must be ignored.
      cur_tag = "stray";
      apb_xfer(1'b0, 16'h0058, 32'h0, 4'h0, 100, 1'b0, TO + 1, 1'b1, 32'h0);
      idle(4, 1'b1);
      idle(2, 1'b0);
      cur_tag = "after_stray";
      apb_xfer(1'b0, 16'h0040, 32'h0, 4'h0, 2, 1'b0, 3, 1'b0, 32'hCAFEBEEF);
      idle(1, 1'b0);

      // Asynchronous reset two cycles into a stalled write.
      cur_tag = "midrst";
      tick();
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 16'h0080; pwdata = 32'h55AA55AA; pstrb = 4'hF;
      lb_wready = 1'b0;
      tick();
      cur_j = 1;
      chk1("mr_wen_t1", lb_wen, 1'b1);
      penable = 1'b1;
      tick();
      cur_j = 2;
      chk1("mr_wen_t2", lb_wen, 1'b1);
      #4;
      rst = 1'b1;
      psel = 1'b0; penable = 1'b0;
      #1;
      chk1("mr_wen_async", lb_wen, 1'b0);
      chk1("mr_pready_async", pready, 1'b0);
      chk("mr_waddr_async", {16'd0, lb_waddr}, 32'd0);
      chk("mr_prdata_async", prdata, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      last_prd = '0;
      idle(5, 1'b0);

      // Randomised traffic against the map model.
      cur_tag = "rand";
      for (int n = 0; n < 150; n++) begin
         wr = 1'($urandom_range(0, 1));
         a  = 16'h0040 + 16'(4 * $urandom_range(0, 7));
         d  = $urandom;
         r  = $urandom_range(0, 9);
         if (r < 7)      k = $urandom_range(1, 4);
         else if (r < 9) k = $urandom_range(TO - 3, TO + 2);
         else            k = 40;
         expect_resp(k, e, err);
         if (err)     ep = '0;
         else if (wr) ep = last_prd;
         else         ep = map_read(a);
         cur_tag = $sformatf("rand%0d", n);
         apb_xfer(wr, a, d, 4'($urandom), k, ($urandom_range(0, 9) == 0), e, err, ep);
         r = $urandom_range(0, 2);
         if (r > 0) idle(r, 1'($urandom_range(0, 1)));
      end
      idle(2, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
